// File: rtl/add_shft_mul.sv
// add_shft_mul: iterative shift-and-add multiply-accumulate, p = a*b + c.
// Retires one multiplier bit per clock. Given a quotient, divisor and remainder from the
// subtract-shift divider it rebuilds the dividend.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  single-cycle request, accepted only in IDLE or DONE
//   a      multiplicand (unsigned, W bits)
//   b      multiplier (unsigned, W bits, consumed LSB first)
//   c      addend (unsigned, W bits, zero-extended)
//   busy   high while an operation is running
//   done   one-cycle pulse when p holds a fresh result
//   p      result register (2W bits), held until the next operation completes
//
// Build option: define EARLY_EXIT_EN to end RUN as soon as the remaining multiplier is zero.
// Without it, latency is fixed at W cycles. Results are identical in both builds.
module add_shft_mul #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned CntW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplr_q, mplr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  p_d;

  logic [2*W-1:0]  sum;
  logic [W-1:0]    mplr_shift;
  logic            last_step;
  logic            accept;

  always_comb begin
    sum        = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mplr_shift = mplr_q >> 1;
`ifdef EARLY_EXIT_EN
    last_step  = (cnt_q == CntW'(W - 1)) || (mplr_shift == '0);
`else
    last_step  = (cnt_q == CntW'(W - 1));
`endif
    accept     = start && ((state_q == StIdle) || (state_q == StDone));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    p_d     = p;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shift;
        cnt_d   = cnt_q + CntW'(1);
        if (last_step) begin
          p_d     = sum;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Start is honoured in IDLE and DONE alike; this overrides DONE's return to IDLE.
    if (accept) begin
      acc_d   = {{W{1'b0}}, c};
      mcand_d = {{W{1'b0}}, a};
      mplr_d  = b;
      cnt_d   = '0;
      state_d = StRun;
`ifdef EARLY_EXIT_EN
      // Nothing to multiply: the result is just the addend.
      if (b == '0) begin
        p_d     = {{W{1'b0}}, c};
        state_d = StDone;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      p       <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      p       <= p_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_add_shft_mul.sv
module tb_add_shft_mul;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a, b, c;
  logic           busy, done;
  logic [2*W-1:0] p;

  int checks = 0;
  int failures = 0;

  add_shft_mul #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c    (c),
    .busy (busy),
    .done (done),
    .p    (p)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edge index (after E0) at which done is first seen.
  function automatic int exp_lat(input logic [W-1:0] mb);
    int k;
`ifdef EARLY_EXIT_EN
    k = 0;
    for (int i = 0; i < int'(W); i++) if (mb[i]) k = i + 1;
`else
    k = W;
`endif
    return k;
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                        input int ep, input string tag);
    int k;
    int nb;
    a = ta; b = tb_; c = tc; start = 1'b1;
    step();  // E0
    start = 1'b0;
    k = 0;
    nb = 0;
    while (!done && k < 20) begin
      if (busy) nb++;
      step();
      k++;
    end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_lat"}, k, exp_lat(tb_));
    chk({tag, "_busycyc"}, nb, exp_lat(tb_));
    chk({tag, "_busy_in_done"}, int'(busy), 0);
    chk({tag, "_p"}, int'(p), ep);
    step();
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_p_held"}, int'(p), ep);
  endtask

  initial begin
    int k;
    int nd;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_p", int'(p), 0);
    step();

    // 14 = 4*3 + 2 (rebuilds 14/3)
    run_op(4'd4, 4'd3, 4'd2, 14, "basic");
    run_op(4'd15, 4'd15, 4'd15, 240, "max");
    run_op(4'd0, 4'd0, 4'd0, 0, "zero");
    run_op(4'd9, 4'd0, 4'd5, 5, "b0");
    run_op(4'd7, 4'd1, 4'd0, 7, "b1");
    run_op(4'd11, 4'd13, 4'd6, 149, "mix");

    // Start during RUN must be ignored.
    a = 4'd4; b = 4'd3; c = 4'd2; start = 1'b1;
    step();  // E0
    start = 1'b0;
    step();  // E1
    a = 4'd1; b = 4'd1; c = 4'd1; start = 1'b1;
    step();  // E2
    start = 1'b0;
    nd = 0;
    if (done) nd++;
    for (int i = 3; i <= 12; i++) begin
      step();
      if (done) nd++;
    end
    chk("ign_done_count", nd, 1);
    chk("ign_p", int'(p), 14);

    // Reset mid-operation.
    a = 4'd4; b = 4'd3; c = 4'd2; start = 1'b1;
    step();  // E0
    start = 1'b0;
    step();  // E1
    rst = 1'b1;
    step();  // E2
    rst = 1'b0;
    chk("midrst_p", int'(p), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    run_op(4'd4, 4'd3, 4'd2, 14, "after_rst");

    // Back-to-back: start held through the DONE cycle.
    a = 4'd4; b = 4'd3; c = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      step();
      k++;
    end
    chk("b2b_first_done", int'(done), 1);
    chk("b2b_first_p", int'(p), 14);
    a = 4'd5; b = 4'd6; c = 4'd3; start = 1'b1;
    step();  // accepting edge
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_p_held", int'(p), 14);
    k = 0;
    nd = 0;
    while (!done && k < 20) begin
      if (p != 8'd14) nd++;
      step();
      k++;
    end
    chk("b2b_p_stable", nd, 0);
    chk("b2b_second_done", int'(done), 1);
    chk("b2b_lat", k, exp_lat(4'd6));
    chk("b2b_p", int'(p), 33);
    step();
    chk("b2b_done_pulse", int'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
